// File: rtl/mips32_pkg.sv
// Shared definitions for the MIPS32 core, its boot-time program loader and
// the loader testbench.
//   loader_state_t : loader FSM states
//   IMEM_ADDR_W    : instruction memory word-address width
//   IMEM_DEPTH     : instruction memory depth in 32-bit words
//   Opcodes        : 6-bit primary opcodes (instr[31:26])
package mips32_pkg;

  localparam int IMEM_ADDR_W = 9;
  localparam int IMEM_DEPTH  = 512;

  typedef enum logic [2:0] {
    HDR_HI,
    HDR_LO,
    DATA,
    CSUM,
    DONE,
    ERR
  } loader_state_t;

  localparam logic [5:0] ADD   = 6'b000000;
  localparam logic [5:0] SUB   = 6'b000001;
  localparam logic [5:0] AND   = 6'b000010;
  localparam logic [5:0] OR    = 6'b000011;
  localparam logic [5:0] SLT   = 6'b000100;
  localparam logic [5:0] MUL   = 6'b000101;
  localparam logic [5:0] LW    = 6'b001000;
  localparam logic [5:0] SW    = 6'b001001;
  localparam logic [5:0] ADDI  = 6'b001010;
  localparam logic [5:0] SUBI  = 6'b001011;
  localparam logic [5:0] SLTI  = 6'b001100;
  localparam logic [5:0] BNEQZ = 6'b001101;
  localparam logic [5:0] BEQZ  = 6'b001110;
  localparam logic [5:0] HLT   = 6'b111111;

endpackage

// File: rtl/mips32_byte_packer.sv
// Packs a stream of bytes, big-endian, into 32-bit words.
//   clk_1      : clock
//   rst        : synchronous active-low reset
//   clr        : synchronous clear of the shift register and byte counter
//   byte_en    : shift byte_in in this cycle
//   byte_in    : incoming byte
//   word_valid : one-cycle pulse, the cycle after the 4th byte of a word
//   word       : packed word (complete while word_valid is high)
//   last_byte  : the next accepted byte completes a word
module mips32_byte_packer (
  input  logic        clk_1,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word,
  output logic        last_byte
);

  logic [31:0] sr_p1;
  logic [1:0]  cnt;
  logic        vld_p1;

  assign last_byte  = (cnt == 2'd3);
  assign word_valid = vld_p1;
  assign word       = sr_p1;

  // Stage p1: shift register and word-complete pulse.
  // A byte of the next word may shift in while vld_p1 is high; word is
  // still the complete value during that cycle.
  always_ff @(posedge clk_1) begin
    if (!rst || clr) begin
      sr_p1  <= '0;
      cnt    <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= byte_en && last_byte;
      if (byte_en) begin
        sr_p1 <= {sr_p1[23:0], byte_in};
        cnt   <= cnt + 2'd1;
      end
    end
  end

endmodule

// File: rtl/mips32_prog_loader.sv
// Boot-time program loader upstream of the MIPS32 instruction fetch stage.
// Accepts a framed byte stream (2-byte big-endian word count N, 4N data
// bytes, 1 checksum byte), writes the words into instruction memory and
// releases the core from reset once the data checksum verifies.
//   clk_1        : clock
//   rst          : synchronous active-low reset
//   in_data      : incoming byte
//   in_valid     : in_data valid
//   in_ready     : loader accepts a byte (transfer on in_valid && in_ready)
//   imem_we      : instruction memory write strobe
//   imem_addr    : instruction memory word address
//   imem_wdata   : instruction word
//   core_rst_n   : active-low core reset, high only after a verified image
//   done         : image loaded and verified (sticky)
//   error        : header or checksum failure (sticky)
//   words_loaded : number of words written so far
module mips32_prog_loader
  import mips32_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk_1,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst_n,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(1) << ADDR_W;

  loader_state_t     state, state_nxt;
  logic [7:0]        cnt_hi;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  hdr_full;
  logic [7:0]        acc;
  logic [ADDR_W-1:0] addr_p1;
  logic              recv, hs, hdr_bad, last_word;
  logic              byte_en, pk_clr, pk_last, pk_vld;
  logic [31:0]       pk_word;

  function automatic logic [7:0] csum_add(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

  assign recv     = (state == HDR_HI) || (state == HDR_LO) ||
                    (state == DATA)   || (state == CSUM);
  // Gated by rst so no byte can be taken while the loader is held in reset.
  assign in_ready = rst && recv;
  assign hs       = in_valid && in_ready;

  assign hdr_full  = CNT_W'({cnt_hi, in_data});
  assign hdr_bad   = (hdr_full == '0) || ({1'b0, hdr_full} > DEPTH_C);
  // The 4th byte of word index words_loaded is arriving; is it the final word?
  assign last_word = ((CNT_W+1)'(words_loaded) + (CNT_W+1)'(1)) == {1'b0, count};

  assign byte_en = hs && (state == DATA);
  assign pk_clr  = hs && (state == HDR_LO);

  mips32_byte_packer u_packer (
    .clk_1      (clk_1),
    .rst        (rst),
    .clr        (pk_clr),
    .byte_en    (byte_en),
    .byte_in    (in_data),
    .word_valid (pk_vld),
    .word       (pk_word),
    .last_byte  (pk_last)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      HDR_HI: if (hs) state_nxt = HDR_LO;
      HDR_LO: if (hs) state_nxt = hdr_bad ? ERR : DATA;
      // Leave DATA on the last byte itself so the checksum byte can arrive
      // in the same cycle as the final write.
      DATA:   if (byte_en && pk_last && last_word) state_nxt = CSUM;
      CSUM:   if (hs) state_nxt = (csum_add(acc, in_data) == 8'd0) ? DONE : ERR;
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk_1) begin
    if (!rst) state <= HDR_HI;
    else      state <= state_nxt;
  end

  // Stage p1: header, checksum, write address and word count registers.
  always_ff @(posedge clk_1) begin
    if (!rst) begin
      cnt_hi       <= '0;
      count        <= '0;
      acc          <= '0;
      addr_p1      <= '0;
      words_loaded <= '0;
      core_rst_n   <= 1'b0;
    end else begin
      if (hs && (state == HDR_HI)) cnt_hi <= in_data;
      if (pk_clr) begin
        count <= hdr_full;
        acc   <= '0;
      end
      if (byte_en) acc <= csum_add(acc, in_data);
      if (byte_en && pk_last) begin
        addr_p1      <= words_loaded[ADDR_W-1:0];
        words_loaded <= words_loaded + 1'b1;
      end
      core_rst_n <= (state_nxt == DONE);
    end
  end

  assign imem_we    = pk_vld;
  assign imem_addr  = addr_p1;
  assign imem_wdata = pk_word;
  assign done       = (state == DONE);
  assign error      = (state == ERR);

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Testbench for mips32_prog_loader: drives framed images, predicts every
// instruction memory write into a scoreboard queue and compares the writes
// (address, data, cycle) and the final status outputs.
module tb_mips32_prog_loader;

  localparam int ADDR_W = 9;

  logic              clk_1 = 1'b0;
  logic              rst = 1'b0;
  logic [7:0]        in_data = 8'd0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_rst_n;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   words_loaded;

  mips32_prog_loader #(.ADDR_W(ADDR_W), .CNT_W(16)) dut (
    .clk_1        (clk_1),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .core_rst_n   (core_rst_n),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk_1 = ~clk_1;

  int cyc = 0;
  always @(posedge clk_1) cyc <= cyc + 1;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    int                cyc;
  } wr_t;

  wr_t         sb[$];
  wr_t         mon_e;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] img [0:511];
  bit          chk_ready = 1'b1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Write monitor: every write must match the oldest predicted write.
  always @(negedge clk_1) begin
    if (imem_we === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", 64'(imem_addr), 64'hFFFF);
      end else begin
        mon_e = sb.pop_front();
        chk("wr_addr", 64'(imem_addr), 64'(mon_e.addr));
        chk("wr_data", 64'(imem_wdata), 64'(mon_e.data));
        chk("wr_cycle", 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  // Presents one byte; returns at the negedge before its handshake edge.
  task automatic send_byte(input logic [7:0] b, input int gap_pct, output bit ok);
    int guard = 0;
    ok = 1'b0;
    while (!ok) begin
      @(negedge clk_1);
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = b;
        if (chk_ready) chk("in_ready_rx", 64'(in_ready), 64'd1);
        if (in_ready) ok = 1'b1;
      end
      guard++;
      if (!ok && guard > 200) begin
        chk("send_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
        return;
      end
    end
  endtask

  // Header n_hdr, then n_bytes data bytes from img, then optionally the
  // checksum byte (correct checksum plus csum_delta).
  task automatic send_frame(input logic [15:0] n_hdr, input int n_bytes,
                            input logic [7:0] csum_delta, input int gap,
                            input bit with_csum);
    logic [7:0]  sum = 8'd0;
    logic [7:0]  b;
    logic [31:0] w;
    bit          ok;
    send_byte(n_hdr[15:8], gap, ok);
    send_byte(n_hdr[7:0], gap, ok);
    for (int k = 0; k < n_bytes; k++) begin
      w   = img[k / 4];
      b   = w[31 - 8 * (k % 4) -: 8];
      sum = sum + b;
      send_byte(b, gap, ok);
      if (ok && (k % 4) == 3)
        sb.push_back('{ADDR_W'(k / 4), w, cyc + 1});
    end
    if (with_csum) begin
      b = (8'd0 - sum) + csum_delta;
      send_byte(b, gap, ok);
      chk("core_rst_n_pre", 64'(core_rst_n), 64'd0);
    end
    @(negedge clk_1);
    in_valid = 1'b0;
  endtask

  task automatic reset_dut();
    rst      = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk_1);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_we", 64'(imem_we), 64'd0);
    chk("rst_addr", 64'(imem_addr), 64'd0);
    chk("rst_wdata", 64'(imem_wdata), 64'd0);
    chk("rst_core_rst_n", 64'(core_rst_n), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_words_loaded", 64'(words_loaded), 64'd0);
    chk("rst_sb_empty", 64'(sb.size()), 64'd0);
    rst = 1'b1;
  endtask

  task automatic final_chk(input bit exp_done, input bit exp_err, input bit exp_crn,
                           input int exp_wl);
    chk("fin_done", 64'(done), 64'(exp_done));
    chk("fin_error", 64'(error), 64'(exp_err));
    chk("fin_core_rst_n", 64'(core_rst_n), 64'(exp_crn));
    chk("fin_in_ready", 64'(in_ready), 64'd0);
    chk("fin_words_loaded", 64'(words_loaded), 64'(exp_wl));
    chk("fin_sb_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Normal load.
    reset_dut();
    img[0] = 32'h28010005;
    img[1] = 32'hFC000000;
    send_frame(16'd2, 8, 8'd0, 0, 1'b1);
    final_chk(1'b1, 1'b0, 1'b1, 2);

    // Same frame with random gaps on in_valid.
    reset_dut();
    send_frame(16'd2, 8, 8'd0, 50, 1'b1);
    final_chk(1'b1, 1'b0, 1'b1, 2);

    // Bad checksum.
    reset_dut();
    img[0] = 32'h00000000;
    send_frame(16'd1, 4, 8'd1, 0, 1'b1);
    final_chk(1'b0, 1'b1, 1'b0, 1);
    repeat (5) @(negedge clk_1);
    final_chk(1'b0, 1'b1, 1'b0, 1);

    // Bad headers: zero count and count above depth.
    reset_dut();
    send_frame(16'h0000, 0, 8'd0, 0, 1'b0);
    final_chk(1'b0, 1'b1, 1'b0, 0);
    reset_dut();
    send_frame(16'h0201, 0, 8'd0, 0, 1'b0);
    final_chk(1'b0, 1'b1, 1'b0, 0);

    // Full depth.
    reset_dut();
    for (int i = 0; i < 512; i++) img[i] = 32'(i);
    send_frame(16'd512, 2048, 8'd0, 0, 1'b1);
    final_chk(1'b1, 1'b0, 1'b1, 512);

    // Reset mid-frame, then a fresh single-word frame.
    reset_dut();
    for (int i = 0; i < 4; i++) img[i] = 32'hA5A50000 + 32'(i);
    send_frame(16'd4, 6, 8'd0, 0, 1'b0);
    chk("mid_words_loaded", 64'(words_loaded), 64'd1);
    reset_dut();
    img[0] = 32'hDEADBEEF;
    send_frame(16'd1, 4, 8'd0, 0, 1'b1);
    final_chk(1'b1, 1'b0, 1'b1, 1);

    repeat (3) @(negedge clk_1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
